// File: rtl/apu_dispatch_master_pkg.sv
// Shared FPU/APU definitions: operand/command/tag widths and the write-back entry type.
package apu_dispatch_master_pkg;

    localparam int C_OP           = 32;
    localparam int C_CMD          = 4;
    localparam int C_RM           = 3;
    localparam int C_FLAG         = 5;
    localparam int C_TAG          = 3;
    localparam int C_APU_MAX_TAGS = 2 ** C_TAG;
    localparam int C_REG_ADDR_W   = 5;

    typedef struct packed {
        logic [C_OP-1:0]         result;
        logic [C_FLAG-1:0]       flags;
        logic [C_REG_ADDR_W-1:0] regaddr;
    } apu_wb_entry_t;

endpackage

// File: rtl/apu_dispatch_master_wb_fifo.sv
// First-word fall-through FIFO of write-back entries; push and pop may coincide, even when full.
module apu_wb_fifo
    import apu_dispatch_master_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  apu_wb_entry_t    push_data,
    input  logic             pop,
    output apu_wb_entry_t    pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    apu_wb_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign pop_data = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST) ? {PTR_W{1'b0}} : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? {PTR_W{1'b0}} : rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apu_dispatch_master.sv
// Initiator side of the APU request/response protocol: tag allocation, ds request, tagged write-back.
// Optional APU_WB_BYPASS_EN: same-cycle write-back of a result when the FIFO is empty and the core is ready.
module apu_dispatch_master
    import apu_dispatch_master_pkg::*;
#(
    parameter int NUM_TAGS      = 4,
    parameter int WB_FIFO_DEPTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Issue_Valid_SI,
    output logic                  Issue_Ready_SO,
    input  logic [C_OP-1:0]       Issue_ArgA_DI,
    input  logic [C_OP-1:0]       Issue_ArgB_DI,
    input  logic [C_CMD-1:0]      Issue_Op_SI,
    input  logic [C_RM-1:0]       Issue_RM_SI,
    input  logic [REG_ADDR_W-1:0] Issue_RegAddr_DI,
    output logic [C_OP-1:0]       arga_ds_d,
    output logic [C_OP-1:0]       argb_ds_d,
    output logic [C_CMD-1:0]      op_ds_d,
    output logic [C_RM-1:0]       flags_ds_d,
    output logic [C_TAG-1:0]      tag_ds_d,
    output logic                  valid_ds_s,
    input  logic                  ready_ds_s,
    input  logic [C_OP-1:0]       result_us_d,
    input  logic [C_FLAG-1:0]     flags_us_d,
    input  logic [C_TAG-1:0]      tag_us_d,
    input  logic                  req_us_s,
    output logic                  WB_Valid_SO,
    input  logic                  WB_Ready_SI,
    output logic [C_OP-1:0]       WB_Result_DO,
    output logic [C_FLAG-1:0]     WB_Flags_DO,
    output logic [REG_ADDR_W-1:0] WB_RegAddr_DO,
    output logic                  Busy_SO,
    output logic                  Err_SO
);

    localparam int TIDX_W = $clog2(NUM_TAGS);
    localparam int CNT_W  = $clog2(WB_FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(WB_FIFO_DEPTH);

    logic [NUM_TAGS-1:0]   tag_valid;
    logic [REG_ADDR_W-1:0] tag_regaddr [NUM_TAGS];
    logic [CNT_W-1:0]      alloc_cnt;
    logic [CNT_W-1:0]      fifo_cnt;
    logic                  free_found;
    logic [TIDX_W-1:0]     free_idx;
    logic [TIDX_W-1:0]     res_idx;
    logic                  res_in_range;
    logic                  issue_fire;
    logic                  res_accept;
    logic                  bypass;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    apu_wb_entry_t         res_entry;
    apu_wb_entry_t         fifo_head;
    apu_wb_entry_t         wb_entry;

    // Lowest-index free tag; scanning downwards lets the lowest index win
    always_comb begin
        free_found = 1'b0;
        free_idx   = {TIDX_W{1'b0}};
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            free_found = free_found | ~tag_valid[i];
            free_idx   = tag_valid[i] ? free_idx : TIDX_W'(i);
        end
    end

    // The credit term keeps outstanding tags plus held entries within the FIFO, so it never overflows
    assign Issue_Ready_SO = free_found
                          && (({1'b0, alloc_cnt} + {1'b0, fifo_cnt}) < CREDIT_MAX)
                          && (!valid_ds_s || ready_ds_s);
    assign issue_fire     = Issue_Valid_SI && Issue_Ready_SO;

    assign res_idx      = tag_us_d[TIDX_W-1:0];
    assign res_in_range = (int'(tag_us_d) < NUM_TAGS);
    assign res_accept   = req_us_s && res_in_range && tag_valid[res_idx];
    assign res_entry    = '{result:  result_us_d,
                            flags:   flags_us_d,
                            regaddr: C_REG_ADDR_W'(tag_regaddr[res_idx])};
    assign fifo_empty   = (fifo_cnt == {CNT_W{1'b0}});

`ifdef APU_WB_BYPASS_EN
    assign bypass   = res_accept && fifo_empty && WB_Ready_SI;
    assign wb_entry = bypass ? res_entry : fifo_head;
`else
    assign bypass   = 1'b0;
    assign wb_entry = fifo_head;
`endif

    assign fifo_push     = res_accept && !bypass;
    assign fifo_pop      = !fifo_empty && WB_Ready_SI;
    assign WB_Valid_SO   = !fifo_empty || bypass;
    assign WB_Result_DO  = wb_entry.result;
    assign WB_Flags_DO   = wb_entry.flags;
    assign WB_RegAddr_DO = REG_ADDR_W'(wb_entry.regaddr);
    assign Busy_SO       = (alloc_cnt != {CNT_W{1'b0}}) || !fifo_empty;

    // ds request register: loads on issue, holds until the responder takes it
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            valid_ds_s <= 1'b0;
            arga_ds_d  <= {C_OP{1'b0}};
            argb_ds_d  <= {C_OP{1'b0}};
            op_ds_d    <= {C_CMD{1'b0}};
            flags_ds_d <= {C_RM{1'b0}};
            tag_ds_d   <= {C_TAG{1'b0}};
        end else if (issue_fire) begin
            valid_ds_s <= 1'b1;
            arga_ds_d  <= Issue_ArgA_DI;
            argb_ds_d  <= Issue_ArgB_DI;
            op_ds_d    <= Issue_Op_SI;
            flags_ds_d <= Issue_RM_SI;
            tag_ds_d   <= C_TAG'(free_idx);
        end else if (ready_ds_s) begin
            valid_ds_s <= 1'b0;
        end
    end

    // Tag table, outstanding count and sticky error; a tag freed this cycle is reusable next cycle
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            tag_valid <= {NUM_TAGS{1'b0}};
            for (int i = 0; i < NUM_TAGS; i++) begin
                tag_regaddr[i] <= {REG_ADDR_W{1'b0}};
            end
            alloc_cnt <= {CNT_W{1'b0}};
            Err_SO    <= 1'b0;
        end else begin
            if (res_accept) begin
                tag_valid[res_idx] <= 1'b0;
            end
            if (issue_fire) begin
                tag_valid[free_idx]   <= 1'b1;
                tag_regaddr[free_idx] <= Issue_RegAddr_DI;
            end
            case ({issue_fire, res_accept})
                2'b10:   alloc_cnt <= alloc_cnt + CNT_W'(1);
                2'b01:   alloc_cnt <= alloc_cnt - CNT_W'(1);
                default: alloc_cnt <= alloc_cnt;
            endcase
            if (req_us_s && !res_accept) begin
                Err_SO <= 1'b1;
            end
        end
    end

    apu_wb_fifo #(
        .DEPTH (WB_FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_wb_fifo (
        .clk       (Clk_CI),
        .rst_n     (Rst_RBI),
        .push      (fifo_push),
        .push_data (res_entry),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_cnt)
    );

endmodule

// File: doc/apu_dispatch_master.md
Name: apu_dispatch_master

Overview:
Initiator end of the marx APU request/response protocol; sits between the core's FP issue stage and an APU responder such as the shared FPU.
- Accepts operations from the core with a valid/ready handshake.
- Allocates a transaction tag and drives the downstream (ds) request channel.
- Matches upstream (us) results by tag and returns them, with the destination register address, through a write-back FIFO.
- Responder latency is arbitrary and results may return out of order.

Parameters:
NUM_TAGS, 4, number of concurrently outstanding transactions; 2 <= NUM_TAGS <= 2**C_TAG.
WB_FIFO_DEPTH, 4, write-back FIFO entries; must be >= NUM_TAGS.
REG_ADDR_W, 5, destination register address width.

Ports:
Clk_CI  in  1  clock.
Rst_RBI  in  1  reset, asynchronous, active-low.
Issue_Valid_SI  in  1  core presents an operation.
Issue_Ready_SO  out  1  operation accepted this cycle when also valid.
Issue_ArgA_DI  in  C_OP  operand A.
Issue_ArgB_DI  in  C_OP  operand B.
Issue_Op_SI  in  C_CMD  opcode.
Issue_RM_SI  in  C_RM  rounding mode.
Issue_RegAddr_DI  in  REG_ADDR_W  destination register.
arga_ds_d  out  C_OP  request operand A.
argb_ds_d  out  C_OP  request operand B.
op_ds_d  out  C_CMD  request opcode.
flags_ds_d  out  C_RM  request rounding mode.
tag_ds_d  out  C_TAG  request tag.
valid_ds_s  out  1  request valid.
ready_ds_s  in  1  responder accepts request.
result_us_d  in  C_OP  returned result.
flags_us_d  in  C_FLAG  returned status flags.
tag_us_d  in  C_TAG  returned tag.
req_us_s  in  1  result valid, single cycle; cannot be back-pressured.
WB_Valid_SO  out  1  write-back entry available.
WB_Ready_SI  in  1  core consumes the write-back entry.
WB_Result_DO  out  C_OP  write-back data.
WB_Flags_DO  out  C_FLAG  write-back flags.
WB_RegAddr_DO  out  REG_ADDR_W  write-back destination.
Busy_SO  out  1  any tag outstanding or FIFO not empty.
Err_SO  out  1  sticky protocol error.

Behaviour:
- Reset values:
  - All ds outputs, WB_Valid_SO, Busy_SO and Err_SO are 0.
  - The tag table (valid bit plus RegAddr per tag) is cleared, and both counters are 0.
  - Issue_Ready_SO is combinational and reads 1 once reset is released.
- Counters:
  - AllocCnt counts tags currently outstanding.
  - FifoCnt counts write-back entries held.
- Issue_Ready_SO = (a free tag exists) AND (AllocCnt + FifoCnt < WB_FIFO_DEPTH) AND (!valid_ds_s OR ready_ds_s).
  - This credit rule guarantees the FIFO never overflows.
- Issue handshake at cycle t:
  - The lowest-index free tag is allocated and RegAddr is stored.
  - The ds request register loads, so valid_ds_s = 1 at t+1.
- Request hold:
  - valid_ds_s and all ds data are held stable until the cycle where ready_ds_s = 1.
  - valid_ds_s clears on the following edge unless a new issue is accepted in that cycle; back-to-back issue gives 1 request per cycle.
- Result acceptance (req_us_s = 1 with an allocated tag):
  - Push {result_us_d, flags_us_d, RegAddr[tag]} into the FIFO and free the tag.
  - AllocCnt decrements by 1 and FifoCnt increments by 1.
- Result with an unallocated tag, or tag >= NUM_TAGS:
  - The result is dropped and Err_SO is set; it clears only on reset.
- Simultaneous allocate and free in one cycle:
  - Allocation uses the pre-free vector, so a freed tag is reusable the next cycle.
  - The counters apply both deltas.
- Write-back FIFO:
  - First-word fall-through; WB_Valid_SO = FifoCnt != 0.
  - Pop on WB_Valid_SO && WB_Ready_SI.
  - Push and pop in the same cycle are allowed, including when full (the credit rule makes a push while full impossible).
  - Pointers wrap modulo WB_FIFO_DEPTH.
- Latency: req_us_s at cycle t gives WB_Valid_SO = 1 at t+1 (without the optional feature).
- Reset mid-operation:
  - All outstanding state and FIFO contents are discarded.
  - Results returning after reset hit free tags and set Err_SO; this is the defined behaviour.

Optional Feature:
APU_WB_BYPASS_EN
- Defined: when the FIFO is empty, req_us_s = 1 with a valid tag, and WB_Ready_SI = 1, the result is driven combinationally on the WB_* outputs in the same cycle.
  - WB_Valid_SO is 1 in that cycle, the FIFO is not written, and the tag is freed.
  - If WB_Ready_SI = 0, the result is pushed as normal.
- Undefined: no bypass; minimum result-to-write-back latency is 1 cycle.

Decomposition:
- fpu_defs provides C_OP, C_CMD, C_RM, C_TAG and C_FLAG.
- Add to it a packed struct apu_wb_entry_t {result, flags, regaddr} and the constant C_APU_MAX_TAGS.
- One sub-module, apu_wb_fifo: parameterised FWFT FIFO of apu_wb_entry_t with push/pop/count ports.
- Tag allocation (priority encoder) stays inline.

Test Plan:
- Single op: issue ArgA=0x3F800000, ArgB=0x40000000, RegAddr=7 with ready_ds_s=1 -> valid_ds_s=1 with tag_ds_d=0 next cycle; responder returns tag 0 -> WB_RegAddr_DO=7 one cycle later; Busy_SO drops after the pop.
- Out-of-order: issue 4 ops (RegAddr 1..4) and return tags in order 3,0,2,1 -> write-back order is RegAddr 4,1,3,2; Issue_Ready_SO=0 after the 4th issue until the first WB pop.
- Request stall: hold ready_ds_s=0 for 5 cycles -> ds outputs stable and Issue_Ready_SO=0 throughout; issue resumes the cycle ready_ds_s rises.
- Write-back back-pressure: WB_Ready_SI=0 with 4 results returned -> FifoCnt=4 and Issue_Ready_SO=0; assert WB_Ready_SI -> 4 pops on consecutive cycles.
- Protocol error: req_us_s with tag 2 when only tag 0 is allocated -> Err_SO=1, FIFO unchanged, tag 0 still outstanding.
- Reset mid-flight with 2 tags outstanding -> all outputs 0; a late result sets Err_SO; with APU_WB_BYPASS_EN, an empty FIFO plus WB_Ready_SI=1 gives a same-cycle write-back.
